// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and bubble insertion; drives the ALU operands and opcode directly.
module ex_issue_stage #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned REG_ADDR_W = 5,
    localparam int unsigned ALUCTR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ALUCTR_W-1:0]   id_aluctr,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_alu1_imm,
    input  logic                  id_alu2_imm,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_dst,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_dst,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [ALUCTR_W-1:0]   alu_aluctr,
    output logic [DATA_WIDTH-1:0] alu1,
    output logic [DATA_WIDTH-1:0] alu2,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite
);

    typedef struct packed {
        logic                  valid;
        logic [ALUCTR_W-1:0]   aluctr;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  rs_used;
        logic                  rt_used;
        logic [DATA_WIDTH-1:0] rs_data;
        logic [DATA_WIDTH-1:0] rt_data;
        logic [DATA_WIDTH-1:0] imm;
        logic                  alu1_imm;
        logic                  alu2_imm;
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
    } ex_reg_t;

    ex_reg_t               ex_q;
    ex_reg_t               ex_d;
    logic [DATA_WIDTH-1:0] fwd_rs;
    logic [DATA_WIDTH-1:0] fwd_rt;

    // Load-use hazard: the load in EX produces a register the ID instruction reads
    always_comb begin
        stall = 1'b0;
        if (id_valid && ex_q.valid && ex_q.memread && (ex_q.dst != '0)) begin
            stall = (id_rs_used && (id_rs == ex_q.dst)) ||
                    (id_rt_used && (id_rt == ex_q.dst));
        end
    end

    // Next EX contents: a zeroed bubble on flush or stall, otherwise the ID fields
    always_comb begin
        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid    = id_valid;
            ex_d.aluctr   = id_aluctr;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rs_used  = id_rs_used;
            ex_d.rt_used  = id_rt_used;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
            ex_d.alu1_imm = id_alu1_imm;
            ex_d.alu2_imm = id_alu2_imm;
            ex_d.dst      = id_dst;
            ex_d.regwrite = id_regwrite & id_valid;
            ex_d.memread  = id_memread  & id_valid;
            ex_d.memwrite = id_memwrite & id_valid;
        end
    end

    // EX register; reset discards whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Operand forwarding: youngest producer (EX/MEM) wins, r0 never forwarded
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (ex_q.rs_used && exmem_regwrite && (exmem_dst != '0) && (exmem_dst == ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (ex_q.rs_used && memwb_regwrite && (memwb_dst != '0) && (memwb_dst == ex_q.rs)) begin
            fwd_rs = memwb_result;
        end

        fwd_rt = ex_q.rt_data;
        if (ex_q.rt_used && exmem_regwrite && (exmem_dst != '0) && (exmem_dst == ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (ex_q.rt_used && memwb_regwrite && (memwb_dst != '0) && (memwb_dst == ex_q.rt)) begin
            fwd_rt = memwb_result;
        end
    end

    // ALU operand muxes and EX-stage outputs
    always_comb begin
        alu1          = ex_q.alu1_imm ? ex_q.imm : fwd_rs;
        alu2          = ex_q.alu2_imm ? ex_q.imm : fwd_rt;
        ex_store_data = fwd_rt;
        ex_valid      = ex_q.valid;
        alu_aluctr    = ex_q.aluctr;
        ex_dst        = ex_q.dst;
        ex_regwrite   = ex_q.regwrite;
        ex_memread    = ex_q.memread;
        ex_memwrite   = ex_q.memwrite;
    end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed, table-driven bench for the ID/EX issue stage.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid;
    logic [3:0]  id_aluctr;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_rs_used, id_rt_used;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu1_imm, id_alu2_imm;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid;
    logic [3:0]  alu_aluctr;
    logic [31:0] alu1, alu2, ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_regwrite, ex_memread, ex_memwrite;

    int n_checks = 0;
    int n_pass   = 0;

    ex_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_aluctr(id_aluctr), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu1_imm(id_alu1_imm), .id_alu2_imm(id_alu2_imm), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .alu_aluctr(alu_aluctr),
        .alu1(alu1), .alu2(alu2), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, vld;
        logic [3:0]  op;
        logic [4:0]  rs, rt;
        logic        ru, tu;
        logic [31:0] rsd, rtd, imm;
        logic        a1i, a2i;
        logic [4:0]  dst;
        logic        rw, mr, mw;
        logic        erw;
        logic [4:0]  edst;
        logic [31:0] eres;
        logic        mrw;
        logic [4:0]  mdst;
        logic [31:0] mres;
        logic        xst, xv, xrw, xmr, xmw;
        logic [4:0]  xdst;
        logic [3:0]  xop;
        logic [31:0] x1, x2, xs;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic fl, input logic vld, input logic [3:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic ru, input logic tu,
        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
        input logic a1i, input logic a2i, input logic [4:0] dst,
        input logic rw, input logic mr, input logic mw,
        input logic erw, input logic [4:0] edst, input logic [31:0] eres,
        input logic mrw, input logic [4:0] mdst, input logic [31:0] mres,
        input logic xst, input logic xv, input logic xrw, input logic xmr, input logic xmw,
        input logic [4:0] xdst, input logic [3:0] xop,
        input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xs);
        vec_t v;
        v.fl = fl; v.vld = vld; v.op = op; v.rs = rs; v.rt = rt; v.ru = ru; v.tu = tu;
        v.rsd = rsd; v.rtd = rtd; v.imm = imm; v.a1i = a1i; v.a2i = a2i; v.dst = dst;
        v.rw = rw; v.mr = mr; v.mw = mw;
        v.erw = erw; v.edst = edst; v.eres = eres; v.mrw = mrw; v.mdst = mdst; v.mres = mres;
        v.xst = xst; v.xv = xv; v.xrw = xrw; v.xmr = xmr; v.xmw = xmw;
        v.xdst = xdst; v.xop = xop; v.x1 = x1; v.x2 = x2; v.xs = xs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; id_valid = v.vld; id_aluctr = v.op; id_rs = v.rs; id_rt = v.rt;
        id_rs_used = v.ru; id_rt_used = v.tu; id_rs_data = v.rsd; id_rt_data = v.rtd;
        id_imm = v.imm; id_alu1_imm = v.a1i; id_alu2_imm = v.a2i; id_dst = v.dst;
        id_regwrite = v.rw; id_memread = v.mr; id_memwrite = v.mw;
        exmem_regwrite = v.erw; exmem_dst = v.edst; exmem_result = v.eres;
        memwb_regwrite = v.mrw; memwb_dst = v.mdst; memwb_result = v.mres;
    endtask

    task automatic check_ex(input string tag, input vec_t v);
        chk({tag, ".ex_valid"},    32'(ex_valid),    32'(v.xv));
        chk({tag, ".ex_regwrite"}, 32'(ex_regwrite), 32'(v.xrw));
        chk({tag, ".ex_memread"},  32'(ex_memread),  32'(v.xmr));
        chk({tag, ".ex_memwrite"}, 32'(ex_memwrite), 32'(v.xmw));
        chk({tag, ".ex_dst"},      32'(ex_dst),      32'(v.xdst));
        chk({tag, ".alu_aluctr"},  32'(alu_aluctr),  32'(v.xop));
        chk({tag, ".alu1"},        alu1,             v.x1);
        chk({tag, ".alu2"},        alu2,             v.x2);
        chk({tag, ".store_data"},  ex_store_data,    v.xs);
    endtask

    vec_t lw8;

    initial begin
        //            fl vld op  rs rt ru tu rsd      rtd      imm      a1 a2 dst rw mr mw  erw edst eres     mrw mdst mres     | st v rw mr mw dst op  alu1     alu2     store
        // EX/MEM beats MEM/WB for rs=3
        vecs[0]  = mk(0, 1, 2, 3, 4, 1, 1, 32'h5,    32'h7,    32'h0,   0, 0, 10, 1, 0, 0,  1, 3, 32'h100,  1, 3, 32'h200,   0, 1, 1, 0, 0, 10, 2, 32'h100,  32'h7,    32'h7);
        // EX/MEM disabled: MEM/WB supplies rs
        vecs[1]  = mk(0, 1, 2, 3, 4, 1, 1, 32'h5,    32'h7,    32'h0,   0, 0, 10, 1, 0, 0,  0, 3, 32'h100,  1, 3, 32'h200,   0, 1, 1, 0, 0, 10, 2, 32'h200,  32'h7,    32'h7);
        // r0 is never forwarded
        vecs[2]  = mk(0, 1, 1, 0, 0, 1, 1, 32'h55,   32'h66,   32'h0,   0, 0, 0,  1, 0, 0,  1, 0, 32'hFFFF, 1, 0, 32'hEEEE,  0, 1, 1, 0, 0, 0,  1, 32'h55,   32'h66,   32'h66);
        // lw r8, 4(r1)
        vecs[3]  = mk(0, 1, 2, 1, 8, 1, 0, 32'h1000, 32'h99,   32'h4,   0, 1, 8,  1, 1, 0,  0, 0, 32'h0,    0, 0, 32'h0,     0, 1, 1, 1, 0, 8,  2, 32'h1000, 32'h4,    32'h99);
        // dependent add: stall, bubble enters EX
        vecs[4]  = mk(0, 1, 3, 8, 9, 1, 1, 32'h11,   32'h22,   32'h0,   0, 0, 12, 1, 0, 0,  1, 8, 32'h1234, 0, 0, 32'h0,     1, 0, 0, 0, 0, 0,  0, 32'h0,    32'h0,    32'h0);
        // re-presented add: issues, rs from MEM/WB
        vecs[5]  = mk(0, 1, 3, 8, 9, 1, 1, 32'h11,   32'h22,   32'h0,   0, 0, 12, 1, 0, 0,  0, 0, 32'h0,    1, 8, 32'hABCD,  0, 1, 1, 0, 0, 12, 3, 32'hABCD, 32'h22,   32'h22);
        vecs[6]  = vecs[3];
        // rs not read: no stall, no forward despite matching EX/MEM
        vecs[7]  = mk(0, 1, 3, 8, 9, 0, 1, 32'h11,   32'h22,   32'h0,   0, 0, 12, 1, 0, 0,  1, 8, 32'h777,  0, 0, 32'h0,     0, 1, 1, 0, 0, 12, 3, 32'h11,   32'h22,   32'h22);
        vecs[8]  = vecs[3];
        // flush together with a stall condition
        vecs[9]  = mk(1, 1, 2, 8, 5, 1, 1, 32'h1,    32'h2,    32'h0,   0, 1, 0,  0, 0, 1,  0, 0, 32'h0,    0, 0, 32'h0,     1, 0, 0, 0, 0, 0,  0, 32'h0,    32'h0,    32'h0);
        // sll: alu1 <- imm, rt=2 from MEM/WB
        vecs[10] = mk(0, 1, 5, 0, 2, 0, 1, 32'h0,    32'hDEAD, 32'h100, 1, 0, 4,  1, 0, 0,  0, 0, 32'h0,    1, 2, 32'h1,     0, 1, 1, 0, 0, 4,  5, 32'h100,  32'h1,    32'h1);
        // sw: alu2 <- imm, store data still forwarded
        vecs[11] = mk(0, 1, 2, 6, 2, 1, 1, 32'h2000, 32'hDEAD, 32'h8,   0, 1, 0,  0, 0, 1,  0, 0, 32'h0,    1, 2, 32'h1,     0, 1, 0, 0, 1, 0,  2, 32'h2000, 32'h8,    32'h1);
        // id_valid=0: control bits masked, other fields loaded
        vecs[12] = mk(0, 0, 7, 1, 3, 0, 0, 32'h33,   32'h44,   32'h0,   0, 0, 9,  1, 1, 1,  0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 0, 0, 0, 9,  7, 32'h33,   32'h44,   32'h44);

        // Reset held two cycles with a valid instruction at ID
        rst = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex_valid",    32'(ex_valid),    32'h0);
        chk("reset.ex_regwrite", 32'(ex_regwrite), 32'h0);
        chk("reset.alu1",        alu1,             32'h0);
        chk("reset.alu2",        alu2,             32'h0);
        chk("reset.stall",       32'(stall),       32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].xst));
            @(posedge clk);
            #1;
            check_ex($sformatf("v%0d", i), vecs[i]);
        end

        // Mid-stream reset discards a load in EX and overrides its stall
        lw8 = vecs[3];
        drive(lw8);
        @(posedge clk);
        #1;
        chk("midrst.pre_memread", 32'(ex_memread), 32'h1);
        drive(vecs[4]);
        #1;
        chk("midrst.pre_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.ex_valid",   32'(ex_valid),   32'h0);
        chk("midrst.ex_memread", 32'(ex_memread), 32'h0);
        chk("midrst.ex_dst",     32'(ex_dst),     32'h0);
        chk("midrst.stall",      32'(stall),      32'h0);

        // Load-use via rt only also stalls for exactly one cycle
        drive(lw8);
        @(posedge clk);
        #1;
        drive(mk(0, 1, 3, 0, 8, 0, 1, 32'h0, 32'h22, 32'h0, 0, 0, 13, 1, 0, 0,
                 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        #1;
        chk("rtuse.stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        chk("rtuse.bubble_valid", 32'(ex_valid), 32'h0);
        chk("rtuse.stall_clear",  32'(stall),    32'h0);
        memwb_regwrite = 1'b1; memwb_dst = 5'd8; memwb_result = 32'h5A5A;
        @(posedge clk);
        #1;
        chk("rtuse.ex_valid", 32'(ex_valid), 32'h1);
        chk("rtuse.alu2",     alu2,          32'h5A5A);
        chk("rtuse.ex_dst",   32'(ex_dst),   32'd13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
